ap_job_sequencer: RTL and testbench

Host-side job sequencer sitting directly upstream of the associative-processor (AP) array port. It accepts a job descriptor and two operand streams, writes operands into AP banks 0 and 1, and triggers the AP operation in `ap_mode`. It waits for `ap_state_irq`, then reads bank 2 back into a result stream. It is the single owner of every AP control signal: `addr`, `data`, `cmd`, `sel_col`, `sel_internal_col`, `ap_mode`, `op_direction`, `write_en` and `read_en`.

---
 rtl/ap_job_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ap_job_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_job_sequencer.sv
// rtl/ap_job_sequencer.sv - AP job sequencer: loads banks 0/1, runs the AP op, streams bank 2 back.
// Optional IRQ watchdog enabled by defining AP_SEQ_TIMEOUT_EN.
module ap_job_sequencer #(
  parameter int WORD_SIZE      = 8,
  parameter int CELL_QUANT     = 512,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [2:0]           job_cmd,
  input  logic                 job_dir,
  input  logic                 job_icol,
  input  logic [ADDR_W-1:0]    job_len_m1,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [ADDR_W-1:0]    ap_addr,
  output logic [WORD_SIZE-1:0] ap_data,
  output logic [2:0]           ap_cmd,
  output logic [1:0]           ap_sel_col,
  output logic                 ap_sel_internal_col,
  output logic                 ap_mode,
  output logic                 ap_op_direction,
  output logic                 ap_write_en,
  output logic                 ap_read_en,
  input  logic [WORD_SIZE-1:0] ap_data_out,
  input  logic                 ap_state_irq,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD0, S_LOAD1, S_START, S_WAIT_IRQ,
    S_RD_ISSUE, S_RD_CAP, S_RD_HOLD, S_DONE
  } state_t;

`ifdef AP_SEQ_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [15:0]       WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(CELL_QUANT - 1);

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      cnt, cnt_nxt;
  logic [ADDR_W-1:0]      len_q;
  logic [2:0]             cmd_q;
  logic                   dir_q;
  logic                   icol_q;
  logic [WORD_SIZE-1:0]   out_data_q;
  logic                   err_q;
  logic [15:0]            wd_cnt;
  logic                   last;
  logic                   wd_hit;
  logic                   accept;

  assign last     = (cnt == len_q);
  assign accept   = (state == S_IDLE) && job_valid;
  assign wd_hit   = WD_EN && (state == S_WAIT_IRQ) && !ap_state_irq && (wd_cnt == WD_LAST);
  assign out_data = out_data_q;
  assign err      = err_q;

  always_comb begin
    state_nxt           = state;
    cnt_nxt             = cnt;
    job_ready           = 1'b0;
    in_ready            = 1'b0;
    out_valid           = 1'b0;
    ap_addr             = '0;
    ap_data             = '0;
    ap_cmd              = 3'd0;
    ap_sel_col          = 2'd0;
    ap_sel_internal_col = 1'b0;
    ap_mode             = 1'b0;
    ap_op_direction     = 1'b0;
    ap_write_en         = 1'b0;
    ap_read_en          = 1'b0;
    done                = 1'b0;
    busy                = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        job_ready = !rst;
        if (job_valid) begin
          cnt_nxt   = '0;
          state_nxt = S_LOAD0;
        end
      end
      S_LOAD0, S_LOAD1: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ap_write_en = 1'b1;
          ap_addr     = cnt;
          ap_data     = in_data;
          ap_sel_col  = (state == S_LOAD0) ? 2'd0 : 2'd1;
          if (last) begin
            cnt_nxt   = '0;
            state_nxt = (state == S_LOAD0) ? S_LOAD1 : S_START;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_START, S_WAIT_IRQ: begin
        ap_mode             = 1'b1;
        ap_cmd              = cmd_q;
        ap_op_direction     = dir_q;
        ap_sel_internal_col = icol_q;
        if (ap_state_irq) begin
          state_nxt = S_RD_ISSUE;
        end else if (wd_hit) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WAIT_IRQ;
        end
      end
      S_RD_ISSUE: begin
        ap_read_en = 1'b1;
        ap_sel_col = 2'd2;
        ap_addr    = cnt;
        state_nxt  = S_RD_CAP;
      end
      S_RD_CAP: begin
        state_nxt = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (last) begin
            cnt_nxt   = '0;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            state_nxt = S_RD_ISSUE;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      cmd_q      <= 3'd0;
      dir_q      <= 1'b0;
      icol_q     <= 1'b0;
      out_data_q <= '0;
      err_q      <= 1'b0;
      wd_cnt     <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        // Out-of-range lengths are clamped so the counter can never run past the array.
        len_q  <= (job_len_m1 > LEN_MAX) ? LEN_MAX : job_len_m1;
        cmd_q  <= job_cmd;
        dir_q  <= job_dir;
        icol_q <= job_icol;
        err_q  <= 1'b0;
      end else if (wd_hit) begin
        err_q <= 1'b1;
      end
      if (state == S_RD_CAP) begin
        out_data_q <= ap_data_out;
      end
      if (WD_EN && state == S_WAIT_IRQ) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else begin
        wd_cnt <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_ap_job_sequencer.sv
// tb/tb_ap_job_sequencer.sv - scoreboard bench for ap_job_sequencer with a behavioural AP model.
module tb_ap_job_sequencer;
  localparam int WS = 8;
  localparam int AW = 10;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [2:0]    job_cmd = 3'd0;
  logic          job_dir = 1'b0;
  logic          job_icol = 1'b0;
  logic [AW-1:0] job_len_m1 = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WS-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WS-1:0] out_data;
  logic [AW-1:0] ap_addr;
  logic [WS-1:0] ap_data;
  logic [2:0]    ap_cmd;
  logic [1:0]    ap_sel_col;
  logic          ap_sel_internal_col;
  logic          ap_mode;
  logic          ap_op_direction;
  logic          ap_write_en;
  logic          ap_read_en;
  logic [WS-1:0] ap_data_out = '0;
  logic          ap_state_irq = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  ap_job_sequencer #(
    .WORD_SIZE(WS), .CELL_QUANT(512), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_cmd(job_cmd),
    .job_dir(job_dir), .job_icol(job_icol), .job_len_m1(job_len_m1),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ap_addr(ap_addr), .ap_data(ap_data), .ap_cmd(ap_cmd), .ap_sel_col(ap_sel_col),
    .ap_sel_internal_col(ap_sel_internal_col), .ap_mode(ap_mode),
    .ap_op_direction(ap_op_direction), .ap_write_en(ap_write_en), .ap_read_en(ap_read_en),
    .ap_data_out(ap_data_out), .ap_state_irq(ap_state_irq),
    .busy(busy), .done(done), .err(err)
  );

  // Bank 2 contents the AP "computed"; read data appears one cycle after ap_read_en.
  logic [WS-1:0] bank2 [0:511];
  always @(posedge clk) if (ap_read_en) ap_data_out <= bank2[ap_addr[8:0]];

  int passed = 0;
  int total  = 0;

  function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endfunction

  logic [19:0] exp_wr  [$];
  logic [11:0] exp_rd  [$];
  logic [7:0]  exp_out [$];
  logic [2:0]  cur_cmd;
  logic        cur_dir, cur_icol;
  int          done_cnt, mode_cycles;

  logic        prev_we, prev_mode, prev_ov, prev_ordy;
  logic [7:0]  prev_data;

  function automatic logic [41:0] all_outs();
    return {job_ready, in_ready, out_valid, out_data, ap_addr, ap_data, ap_cmd, ap_sel_col,
            ap_sel_internal_col, ap_mode, ap_op_direction, ap_write_en, ap_read_en, busy, done, err};
  endfunction

  // Monitor: samples on the falling edge, pops expectations as the DUT produces traffic.
  always @(negedge clk) begin
    logic [19:0] ew;
    logic [11:0] er;
    logic [7:0]  eo;
    if (rst) begin
      prev_we = 0; prev_mode = 0; prev_ov = 0; prev_ordy = 0; prev_data = '0;
    end else begin
      if (ap_write_en || ap_read_en)
        chk(!(ap_write_en && ap_read_en) && !ap_mode, "en_exclusive",
            {ap_write_en, ap_read_en, ap_mode}, {ap_write_en, ap_read_en, 1'b0});
      if (ap_write_en) begin
        if (exp_wr.size() == 0) chk(1'b0, "wr_extra", {ap_sel_col, ap_addr, ap_data}, 0);
        else begin
          ew = exp_wr.pop_front();
          chk({ap_sel_col, ap_addr, ap_data} == ew, "write", {ap_sel_col, ap_addr, ap_data}, ew);
        end
      end
      if (ap_read_en) begin
        if (exp_rd.size() == 0) chk(1'b0, "rd_extra", {ap_sel_col, ap_addr}, 0);
        else begin
          er = exp_rd.pop_front();
          chk({ap_sel_col, ap_addr} == er, "read", {ap_sel_col, ap_addr}, er);
        end
      end
      if (ap_mode && !prev_mode)
        chk(prev_we && exp_wr.size() == 0, "mode_rise", {prev_we, 8'(exp_wr.size())}, 9'h100);
      if (ap_mode) begin
        mode_cycles++;
        chk({ap_cmd, ap_op_direction, ap_sel_internal_col} == {cur_cmd, cur_dir, cur_icol},
            "mode_fields", {ap_cmd, ap_op_direction, ap_sel_internal_col}, {cur_cmd, cur_dir, cur_icol});
      end
      if (out_valid && prev_ov && !prev_ordy)
        chk(out_data == prev_data, "out_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk(1'b0, "out_extra", out_data, 0);
        else begin
          eo = exp_out.pop_front();
          chk(out_data == eo, "out_data", out_data, eo);
        end
      end
      if (done) done_cnt++;
      prev_we = ap_write_en; prev_mode = ap_mode;
      prev_ov = out_valid; prev_ordy = out_ready; prev_data = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // irq_delay < 0: never raise the IRQ and return once the load phase is over.
  task automatic run_job(input int n, input logic [2:0] cmd, input bit dir, input bit icol,
                         input int irq_delay, input int gap_mode, input int bp_mode, input bit directed);
    logic [7:0] op [$];
    int beats, guard, hold;
    bit acc, hs;
    op.delete();
    for (int i = 0; i < 2 * n; i++)
      op.push_back(directed ? ((i < n) ? 8'(8'h11 + i) : 8'(8'h21 + i - n)) : 8'($urandom));
    for (int i = 0; i < n; i++) bank2[i] = directed ? 8'(8'hA0 + i) : 8'($urandom);
    for (int i = 0; i < 2 * n; i++)
      exp_wr.push_back({((i < n) ? 2'd0 : 2'd1), 10'(i % n), op[i]});
    if (irq_delay >= 0) begin
      for (int i = 0; i < n; i++) begin
        exp_rd.push_back({2'd2, 10'(i)});
        exp_out.push_back(bank2[i]);
      end
    end
    cur_cmd = cmd; cur_dir = dir; cur_icol = icol;
    done_cnt = 0; mode_cycles = 0;

    job_valid = 1'b1; job_cmd = cmd; job_dir = dir; job_icol = icol; job_len_m1 = 10'(n - 1);
    guard = 0;
    while (!job_ready && guard < 50) begin step(); guard++; end
    chk(job_ready, "job_accept", job_ready, 1);
    step();
    job_valid = 1'b0;
    job_cmd = 3'($urandom); job_dir = 1'($urandom); job_icol = 1'($urandom);
    job_len_m1 = 10'($urandom);
    chk({job_ready, busy} == 2'b01, "busy_in_job", {job_ready, busy}, 2'b01);

    beats = 0; guard = 0;
    while (beats < 2 * n && guard < 10 * n + 100) begin
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ($urandom % 3) != 0;
        default: in_valid = (guard % 3) != 2;
      endcase
      in_data = op[beats];
      ap_state_irq = ($urandom % 4) == 0;
      acc = in_valid && in_ready;
      step();
      if (acc) beats++;
      guard++;
    end
    in_valid = 1'b0; in_data = '0; ap_state_irq = 1'b0;
    chk(beats == 2 * n, "load_beats", beats, 2 * n);
    if (irq_delay < 0) return;

    guard = 0;
    while (!ap_mode && guard < 20) begin step(); guard++; end
    repeat (irq_delay) step();
    ap_state_irq = 1'b1;
    step();
    ap_state_irq = 1'b0;

    hold = 0; guard = 0;
    while (done_cnt == 0 && guard < 20 * n + 200) begin
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = out_valid && hold >= 5;
        default: out_ready = 1'($urandom);
      endcase
      ap_state_irq = ($urandom % 5) == 0;
      hs = out_valid && out_ready;
      step();
      hold = hs ? 0 : (out_valid ? hold + 1 : hold);
      guard++;
    end
    out_ready = 1'b0; ap_state_irq = 1'b0;
    step(); step();
    chk(done_cnt == 1, "done_pulses", done_cnt, 1);
    chk(exp_wr.size() + exp_rd.size() + exp_out.size() == 0, "queues_empty",
        exp_wr.size() + exp_rd.size() + exp_out.size(), 0);
    chk({busy, err} == 2'b00, "idle_after_job", {busy, err}, 0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(all_outs() == '0, "reset_outputs", all_outs(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(job_ready == 1'b1, "ready_after_reset", job_ready, 1);
    @(posedge clk); #1;

    run_job(4, 3'd5, 1'b1, 1'b0, 10, 0, 0, 1'b1);
    run_job(4, 3'd2, 1'b0, 1'b1, 3, 0, 1, 1'b1);
    run_job(2, 3'd7, 1'b1, 1'b1, 0, 0, 0, 1'b0);
    run_job(1, 3'd1, 1'b0, 1'b0, 4, 1, 0, 1'b0);
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(1, 16), 3'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 12), 1, 2, 1'b0);
    run_job(512, 3'd3, 1'b1, 1'b0, 5, 2, 0, 1'b0);

`ifdef AP_SEQ_TIMEOUT_EN
    run_job(3, 3'd6, 1'b1, 1'b1, -1, 0, 0, 1'b0);
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin step(); guard++; end
    step();
    chk(mode_cycles == TO + 1, "timeout_mode_cycles", mode_cycles, TO + 1);
    chk(done_cnt == 1, "timeout_done", done_cnt, 1);
    chk({err, busy} == 2'b10, "timeout_err", {err, busy}, 2'b10);
    repeat (5) step();
    chk(err == 1'b1, "err_hold", err, 1);
`else
    run_job(3, 3'd6, 1'b1, 1'b1, -1, 0, 0, 1'b0);
    repeat (10000) step();
    chk({busy, ap_mode, err} == 3'b110, "no_watchdog_wait", {busy, ap_mode, err}, 3'b110);
    rst = 1'b1;
    step(); step();
    chk(all_outs() == '0, "midjob_reset", all_outs(), 0);
    rst = 1'b0;
    #1;
    chk(job_ready == 1'b1, "ready_after_abort", job_ready, 1);
    step();
`endif
    run_job(3, 3'd4, 1'b0, 1'b1, 2, 1, 2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
